// File: rtl/adc_serial_emulator_if.sv
// adc_serial_emulator_if: sample-pair handshake feeding the ADC emulator holding register.
interface adc_serial_emulator_if #(parameter int DATA_W = 12);
  logic valid;
  logic ready;
  logic [DATA_W-1:0] ch0;
  logic [DATA_W-1:0] ch1;
  modport master(output valid, ch0, ch1, input ready);
  modport slave(input valid, ch0, ch1, output ready);
endinterface

// File: rtl/adc_serial_emulator.sv
// adc_serial_emulator: serial dual-channel ADC stand-in driven by oversampled CS/SCLK.
// Define ADC_EMU_RAMP_PATTERN_EN to replace the sample handshake with an internal ramp.
module adc_serial_emulator #(
  parameter int DATA_W      = 12,
  parameter int LEAD_ZEROS  = 2,
  parameter int TRAIL_ZEROS = 2,
  parameter int FRAME_BITS  = LEAD_ZEROS + DATA_W + TRAIL_ZEROS
) (
  input  logic        clk_50M,
  input  logic        reset,
  input  logic        adc_cs_n,
  input  logic        adc_sclk,
  output logic        sdata0,
  output logic        sdata1,
  adc_serial_emulator_if.slave smp,
  output logic        frame_done,
  output logic        frame_abort,
  output logic        underrun,
  output logic [15:0] frame_count
);
  localparam int CW = $clog2(FRAME_BITS + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, WAIT_CS} state_t;
  state_t                state_q;
  logic [2:0]            cs_q, sclk_q;
  logic [FRAME_BITS-1:0] sh0_q, sh1_q, f0, f1;
  logic [CW-1:0]         bit_cnt_q, bit_nxt;
  logic [DATA_W-1:0]     w0, w1;
  logic [15:0]           fc_q;
  logic have, cs_fall, cs_rise, sclk_fall, sd0_q, sd1_q, done_q, abort_q, urun_q;
`ifdef ADC_EMU_RAMP_PATTERN_EN
  logic [DATA_W-1:0] ramp_q;
  assign w0        = ramp_q;
  assign w1        = ~ramp_q;
  assign have      = 1'b1;
  assign smp.ready = 1'b0;
`else
  logic [DATA_W-1:0] hold0_q, hold1_q, last0_q, last1_q;
  logic              pend_q, accept;
  assign have      = pend_q;
  assign w0        = pend_q ? hold0_q : last0_q;
  assign w1        = pend_q ? hold1_q : last1_q;
  assign smp.ready = ~pend_q;
  assign accept    = smp.valid & ~pend_q;
`endif
  assign f0        = {{LEAD_ZEROS{1'b0}}, w0, {TRAIL_ZEROS{1'b0}}};
  assign f1        = {{LEAD_ZEROS{1'b0}}, w1, {TRAIL_ZEROS{1'b0}}};
  assign cs_fall   = cs_q[2] & ~cs_q[1];
  assign cs_rise   = ~cs_q[2] & cs_q[1];
  assign sclk_fall = sclk_q[2] & ~sclk_q[1];
  assign bit_nxt   = bit_cnt_q + 1'b1;
  assign sdata0      = sd0_q;
  assign sdata1      = sd1_q;
  assign frame_done  = done_q;
  assign frame_abort = abort_q;
  assign underrun    = urun_q;
  assign frame_count = fc_q;
  always_ff @(posedge clk_50M or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cs_q      <= '1;
      sclk_q    <= '0;
      sh0_q     <= '0;
      sh1_q     <= '0;
      bit_cnt_q <= '0;
      sd0_q     <= 1'b0;
      sd1_q     <= 1'b0;
      done_q    <= 1'b0;
      abort_q   <= 1'b0;
      urun_q    <= 1'b0;
      fc_q      <= '0;
`ifdef ADC_EMU_RAMP_PATTERN_EN
      ramp_q    <= '0;
`else
      hold0_q   <= '0;
      hold1_q   <= '0;
      last0_q   <= '0;
      last1_q   <= '0;
      pend_q    <= 1'b0;
`endif
    end else begin
      cs_q    <= {cs_q[1:0], adc_cs_n};
      sclk_q  <= {sclk_q[1:0], adc_sclk};
      done_q  <= 1'b0;
      abort_q <= 1'b0;
      urun_q  <= 1'b0;
      case (state_q)
        IDLE: if (cs_fall) begin
          // first frame bit goes out now; the register keeps the rest, MSB next
          sd0_q     <= f0[FRAME_BITS-1];
          sd1_q     <= f1[FRAME_BITS-1];
          sh0_q     <= f0 << 1;
          sh1_q     <= f1 << 1;
          bit_cnt_q <= '0;
          urun_q    <= ~have;
          state_q   <= SHIFT;
`ifndef ADC_EMU_RAMP_PATTERN_EN
          if (pend_q) begin
            last0_q <= hold0_q;
            last1_q <= hold1_q;
            pend_q  <= 1'b0;
          end
`endif
        end
        SHIFT: if (cs_rise) begin
          abort_q <= 1'b1;
          sd0_q   <= 1'b0;
          sd1_q   <= 1'b0;
          state_q <= IDLE;
        end else if (sclk_fall) begin
          bit_cnt_q <= bit_nxt;
          if (bit_nxt == CW'(FRAME_BITS)) begin
            sd0_q   <= 1'b0;
            sd1_q   <= 1'b0;
            done_q  <= 1'b1;
            fc_q    <= fc_q + 1'b1;
            state_q <= WAIT_CS;
`ifdef ADC_EMU_RAMP_PATTERN_EN
            ramp_q  <= ramp_q + 1'b1;
`endif
          end else begin
            sd0_q <= sh0_q[FRAME_BITS-1];
            sd1_q <= sh1_q[FRAME_BITS-1];
            sh0_q <= sh0_q << 1;
            sh1_q <= sh1_q << 1;
          end
        end
        WAIT_CS: if (cs_rise) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
`ifndef ADC_EMU_RAMP_PATTERN_EN
      if (accept) begin
        hold0_q <= smp.ch0;
        hold1_q <= smp.ch1;
        pend_q  <= 1'b1;
      end
`endif
    end
  end
endmodule

// File: tb/tb_adc_serial_emulator.sv
// tb_adc_serial_emulator: drives CS/SCLK like the controller and scoreboards sdata bits.
module tb_adc_serial_emulator;
  logic clk = 1'b0, rst = 1'b1, cs_n = 1'b1, sclk = 1'b0;
  logic sd0, sd1, done, abort, urun;
  logic [15:0] fc;
  int checks = 0, errors = 0, n_done = 0, n_abort = 0, n_urun = 0, u;
  logic [1:0] exp_q[$];
`ifdef ADC_EMU_RAMP_PATTERN_EN
  localparam logic RDY = 1'b0;
`else
  localparam logic RDY = 1'b1;
`endif
  adc_serial_emulator_if #(.DATA_W(12)) smp();
  adc_serial_emulator dut (
    .clk_50M(clk), .reset(rst), .adc_cs_n(cs_n), .adc_sclk(sclk),
    .sdata0(sd0), .sdata1(sd1), .smp(smp),
    .frame_done(done), .frame_abort(abort), .underrun(urun), .frame_count(fc)
  );
  always #10 clk = ~clk;
  always @(posedge clk) begin
    if (done) n_done++;
    if (abort) n_abort++;
    if (urun) n_urun++;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic half();
    repeat (6) @(negedge clk);
  endtask
  task automatic offer(input logic [11:0] a, input logic [11:0] b);
    smp.ch0 = a;
    smp.ch1 = b;
    smp.valid = 1'b1;
    @(negedge clk);
    smp.valid = 1'b0;
  endtask
  // mode 0: full frame, 1: CS raised early (abort), 2: leave CS low
  task automatic frame(input int nfall, input int mode, input logic [11:0] a, input logic [11:0] b);
    logic [15:0] f0, f1;
    logic [1:0] e;
    int d0, a0;
    f0 = {2'b00, a, 2'b00};
    f1 = {2'b00, b, 2'b00};
    d0 = n_done;
    a0 = n_abort;
    for (int i = 0; i < nfall; i++) exp_q.push_back({f0[15-i], f1[15-i]});
    cs_n = 1'b0;
    half();
    chk("ready_in_frame", smp.ready, RDY);
    for (int i = 0; i < nfall; i++) begin
      sclk = 1'b1;
      if (exp_q.size() == 0) chk("queue_empty", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("sdata0", sd0, e[1]);
        chk("sdata1", sd1, e[0]);
      end
      half();
      sclk = 1'b0;
      half();
    end
    if (mode == 2) return;
    if (mode == 0) begin
      chk("frame_done", n_done - d0, 1);
      chk("sdata_end", {sd0, sd1}, 0);
    end
    cs_n = 1'b1;
    half();
    if (mode == 1) begin
      chk("frame_abort", n_abort - a0, 1);
      chk("sdata_abort", {sd0, sd1}, 0);
      chk("done_on_abort", n_done - d0, 0);
    end else chk("abort_none", n_abort - a0, 0);
  endtask
  initial begin
    smp.valid = 1'b0;
    smp.ch0 = '0;
    smp.ch1 = '0;
    repeat (3) @(negedge clk);
    chk("rst_sdata", {sd0, sd1}, 0);
    chk("rst_ready", smp.ready, RDY);
    chk("rst_count", fc, 0);
    chk("rst_pulses", {done, abort, urun}, 0);
    rst = 1'b0;
    half();
`ifdef ADC_EMU_RAMP_PATTERN_EN
    u = n_urun;
    for (int k = 0; k < 3; k++) begin
      frame(16, 0, 12'(k), ~12'(k));
      chk("ramp_count", fc, k + 1);
    end
    chk("ramp_no_underrun", n_urun - u, 0);
`else
    offer(12'hABC, 12'h123);
    chk("ready_pending", smp.ready, 0);
    u = n_urun;
    frame(16, 0, 12'hABC, 12'h123);
    chk("count1", fc, 1);
    chk("no_underrun1", n_urun - u, 0);
    u = n_urun;
    frame(16, 0, 12'hABC, 12'h123);
    chk("underrun2", n_urun - u, 1);
    chk("count2", fc, 2);
    offer(12'h5A5, 12'hA5A);
    chk("ready_pending2", smp.ready, 0);
    offer(12'h111, 12'h222);
    frame(7, 1, 12'h5A5, 12'hA5A);
    chk("count_after_abort", fc, 2);
    chk("ready_after_abort", smp.ready, 1);
    offer(12'h111, 12'h222);
    u = n_urun;
    frame(16, 0, 12'h111, 12'h222);
    chk("no_underrun3", n_urun - u, 0);
    chk("count3", fc, 3);
    offer(12'h0F0, 12'hF0F);
    frame(9, 2, 12'h0F0, 12'hF0F);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_sdata", {sd0, sd1}, 0);
    chk("midrst_ready", smp.ready, 1);
    chk("midrst_count", fc, 0);
    cs_n = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    half();
    offer(12'h7E1, 12'h18E);
    u = n_urun;
    frame(16, 0, 12'h7E1, 12'h18E);
    chk("no_underrun4", n_urun - u, 0);
    chk("count_after_rst", fc, 1);
`endif
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/adc_serial_emulator.md
Name: adc_serial_emulator

Overview:
- Behavioural stand-in for the dual-output 12-bit serial ADC, in synthesisable RTL.
- Responds to the CS/SCLK pair that the ADC controller drives, and shifts two 12-bit channel words out on SDATA0/SDATA1 using the ADC's frame format.
- Used on a spare FPGA bank or in loopback builds so the ADC controller and sensor chain can be exercised without a real ADC.
- Runs on the 50 MHz system clock and oversamples the incoming CS/SCLK.

Parameters:
- DATA_W, 12: sample width per channel.
- LEAD_ZEROS, 2: zero bits sent before the MSB.
- TRAIL_ZEROS, 2: zero bits sent after the LSB.
- FRAME_BITS, LEAD_ZEROS+DATA_W+TRAIL_ZEROS (16): SCLK falling edges in a complete frame.

Ports:
- clk_50M  in  1  system clock. Incoming SCLK must be ≤ clk_50M/8.
- reset  in  1  asynchronous, active-high reset.
- adc_cs_n  in  1  chip select from the controller, active low, asynchronous to clk_50M.
- adc_sclk  in  1  serial clock from the controller, asynchronous to clk_50M.
- sdata0  out  1  serial data, channel 0.
- sdata1  out  1  serial data, channel 1.
- smp_valid  in  1  new sample pair offered.
- smp_ready  out  1  holding register can accept a sample.
- smp_ch0  in  DATA_W  channel 0 word.
- smp_ch1  in  DATA_W  channel 1 word.
- frame_done  out  1  one-cycle pulse when a complete frame finishes.
- frame_abort  out  1  one-cycle pulse when CS rises before FRAME_BITS falling edges.
- underrun  out  1  one-cycle pulse when a frame starts with no new sample pending.
- frame_count  out  16  count of completed frames; wraps at 0xFFFF→0.

Behaviour:
- Reset (async, active-high) sets the following; it applies identically mid-frame, abandoning the frame:
  - state=IDLE.
  - sdata0=sdata1=0; smp_ready=1.
  - frame_done=frame_abort=underrun=0.
  - frame_count=0; holding register, last word and pending flag all 0.
- Synchronisation:
  - adc_cs_n and adc_sclk each pass through 2 flip-flops, plus a third stage for edge detection.
  - Edge detection is valid 3 clk_50M cycles after the pin transition.
  - adc_cs_n synchroniser flops reset to 1; adc_sclk flops reset to 0.
- Sample handshake:
  - A sample is accepted when smp_valid & smp_ready; it loads the holding register and sets pending.
  - smp_ready = ~pending.
- State IDLE, on CS falling edge:
  - If pending: load both shift registers from the holding register and clear pending. smp_ready rises the next cycle.
  - If not pending: reload the last transmitted words and pulse underrun.
  - Each shift register holds {LEAD_ZEROS zeros, word MSB-first, TRAIL_ZEROS zeros}.
  - Clear bit_cnt; drive bit 0 on sdata0/1 in the same cycle as edge detection; go to SHIFT.
- State SHIFT:
  - On each synchronised SCLK falling edge: bit_cnt+1 and present the next bit. The controller samples on the SCLK rising edge.
  - When bit_cnt reaches FRAME_BITS (the 16th falling edge): drive sdata 0, pulse frame_done, increment frame_count, go to WAIT_CS.
  - On CS rising edge first: pulse frame_abort, drive sdata 0, go to IDLE. frame_count is unchanged and the sample stays consumed.
- State WAIT_CS:
  - sdata held 0; extra SCLK edges are ignored.
  - On CS rising edge, go to IDLE.
- Simultaneous events:
  - CS rising edge and final SCLK falling edge detected in the same cycle: CS wins, giving an abort.
  - Sample accept on the same cycle as frame start cannot occur, because smp_ready=0 whenever pending.
- A CS falling edge while not in IDLE is ignored.
- SCLK edges in IDLE are ignored.
- Outputs are registered; sdata changes 1 clk_50M cycle after the detected SCLK falling edge, i.e. ≤4 cycles of pin-to-pin latency.

Optional Feature:
- Macro: ADC_EMU_RAMP_PATTERN_EN.
- Defined:
  - An internal DATA_W-bit ramp replaces smp_ch0/smp_ch1.
  - Frame N sends ch0=N mod 2^DATA_W and ch1=~ch0.
  - The ramp increments only on frame_done.
  - pending is treated as always 1, so underrun never pulses.
  - smp_ready is tied 0 and smp_* inputs are ignored.
- Not defined: the external handshake is used as described above.

Test Plan:
- After reset, load ch0=0xABC, ch1=0x123. Run a 16-clock frame at SCLK=4 MHz → sdata0 bits 00_101010111100_00, sdata1 00_000100100011_00; frame_done pulses once; frame_count=1.
- Run a second frame with no new sample → underrun pulses at CS fall; the frame resends 0xABC/0x123.
- Raise CS after 7 SCLK falling edges → frame_abort pulses, sdata=0, frame_count unchanged; the next frame starts cleanly at bit 0.
- Offer smp_valid with pending=1 → smp_ready=0 and the sample is not accepted; after the next CS fall smp_ready=1 and acceptance succeeds.
- Assert reset at bit 9 of a frame → outputs 0, state IDLE, pending 0; a later frame with a new sample transmits correctly.
- With ADC_EMU_RAMP_PATTERN_EN defined, run 3 frames → ch0 = 0x000, 0x001, 0x002 and ch1 = 0xFFF, 0xFFE, 0xFFD.
